// File: rtl/fetch_pc_generator_pkg.sv
// Shared fetch definitions: FSM encodings, instruction size, alignment.
// Reused by the fetch PC generator and the execute-stage redirect logic.
package fetch_pc_generator_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] L_INST_BYTES = 32'd4;
    localparam logic [31:0] L_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & L_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_pc_generator.sv
// Fetch-address generator: one predictor search per cycle, steers to
// predicted targets, presents {addr, prediction} slots to fetch.
module fetch_pc_generator #(
    parameter logic [31:0] P_RESET_PC = 32'h0000_0000
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iREDIRECT_VALID,
    input  logic [31:0] iREDIRECT_ADDR,
    input  logic        iHALT_REQ,
    output logic        oPRED_SEARCH_STB,
    output logic [31:0] oPRED_SEARCH_ADDR,
    output logic        oPRED_SEARCH_LOCK,
    input  logic        iPRED_VALID,
    input  logic        iPRED_BRANCH,
    input  logic [31:0] iPRED_ADDR,
    output logic        oFETCH_REQ,
    output logic [31:0] oFETCH_ADDR,
    output logic        oFETCH_PRED_BRANCH,
    output logic [31:0] oFETCH_PRED_ADDR,
    input  logic        iFETCH_BUSY
);
    import fetch_pc_generator_pkg::*;

    fetch_state_t r_state;
    fetch_state_t next_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_if_addr;
    logic         r_if_valid;
    logic         stall;
    logic         taken;
    logic         run_go;
    logic         stb;
    logic         lock;

    // A result is only meaningful for the slot in flight; this masks
    // results of squashed wrong-path searches.
    assign taken  = r_if_valid && iPRED_VALID && iPRED_BRANCH;
    assign stall  = r_if_valid && iFETCH_BUSY;
    assign run_go = !iREDIRECT_VALID && (r_state == ST_RUN) && !stall;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= next_state;
        end
    end

    always_comb begin
        next_state = r_state;
        if (iREDIRECT_VALID) begin
            next_state = ST_RUN;
        end else begin
            unique case (r_state)
                ST_RESET: next_state = ST_RUN;
                ST_RUN: begin
                    if (!stall && iHALT_REQ) begin
                        next_state = ST_HALT;
                    end
                end
                ST_HALT: next_state = ST_HALT;
                default: next_state = ST_RESET;
            endcase
        end
    end

    always_comb begin
        stb  = 1'b0;
        lock = 1'b0;
        if (!iREDIRECT_VALID && (r_state == ST_RUN)) begin
            lock = stall;
            stb  = !stall && !iHALT_REQ;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_pc       <= word_align(P_RESET_PC);
            r_if_valid <= 1'b0;
            r_if_addr  <= 32'h0;
        end else if (iREDIRECT_VALID) begin
            r_pc       <= word_align(iREDIRECT_ADDR);
            r_if_valid <= 1'b0;
        end else if (run_go) begin
            if (taken) begin
                r_pc       <= word_align(iPRED_ADDR);
                r_if_valid <= 1'b0;
            end else if (iHALT_REQ) begin
                r_if_valid <= 1'b0;
            end else begin
                r_pc       <= r_pc + L_INST_BYTES;
                r_if_valid <= 1'b1;
                r_if_addr  <= r_pc;
            end
        end else if (r_state != ST_RUN) begin
            r_if_valid <= 1'b0;
        end
    end

    assign oPRED_SEARCH_STB   = stb;
    assign oPRED_SEARCH_ADDR  = stb ? r_pc : 32'h0;
    assign oPRED_SEARCH_LOCK  = lock;
    assign oFETCH_REQ         = r_if_valid;
    assign oFETCH_ADDR        = r_if_addr;
    assign oFETCH_PRED_BRANCH = taken;
    assign oFETCH_PRED_ADDR   = taken ? word_align(iPRED_ADDR) : 32'h0;

endmodule

// File: tb/tb_fetch_pc_generator.sv
// Bench for fetch_pc_generator: directed scenarios plus random traffic,
// checked against a program-order slot-stream model.
module tb_fetch_pc_generator;

    logic        iCLOCK = 1'b0;
    logic        inRESET = 1'b0;
    logic        iREDIRECT_VALID = 1'b0;
    logic [31:0] iREDIRECT_ADDR = 32'h0;
    logic        iHALT_REQ = 1'b0;
    logic        oPRED_SEARCH_STB;
    logic [31:0] oPRED_SEARCH_ADDR;
    logic        oPRED_SEARCH_LOCK;
    logic        iPRED_VALID = 1'b0;
    logic        iPRED_BRANCH = 1'b0;
    logic [31:0] iPRED_ADDR = 32'h0;
    logic        oFETCH_REQ;
    logic [31:0] oFETCH_ADDR;
    logic        oFETCH_PRED_BRANCH;
    logic [31:0] oFETCH_PRED_ADDR;
    logic        iFETCH_BUSY = 1'b0;

    fetch_pc_generator #(.P_RESET_PC(32'h0000_0100)) dut (
        .iCLOCK            (iCLOCK),
        .inRESET           (inRESET),
        .iREDIRECT_VALID   (iREDIRECT_VALID),
        .iREDIRECT_ADDR    (iREDIRECT_ADDR),
        .iHALT_REQ         (iHALT_REQ),
        .oPRED_SEARCH_STB  (oPRED_SEARCH_STB),
        .oPRED_SEARCH_ADDR (oPRED_SEARCH_ADDR),
        .oPRED_SEARCH_LOCK (oPRED_SEARCH_LOCK),
        .iPRED_VALID       (iPRED_VALID),
        .iPRED_BRANCH      (iPRED_BRANCH),
        .iPRED_ADDR        (iPRED_ADDR),
        .oFETCH_REQ        (oFETCH_REQ),
        .oFETCH_ADDR       (oFETCH_ADDR),
        .oFETCH_PRED_BRANCH(oFETCH_PRED_BRANCH),
        .oFETCH_PRED_ADDR  (oFETCH_PRED_ADDR),
        .iFETCH_BUSY       (iFETCH_BUSY)
    );

    always #5 iCLOCK = ~iCLOCK;

    localparam logic [31:0] MASK = 32'hFFFF_FFFC;

    int n_vec = 0;
    int n_bad = 0;

    // predictor contents: search address -> predicted target
    logic [31:0] btb [logic [31:0]];

    // predictor output registers
    logic        pv, pb;
    logic [31:0] pa;
    logic        prev_stb, prev_lock;
    logic [31:0] prev_saddr;

    // slot-stream model
    int          mstate;      // 1 running, 2 halted
    logic [31:0] exp_next;    // next slot address in program order
    int          redir_age;   // cycles since redirect (0 = none)
    logic [31:0] redir_tgt;
    int          bubble;      // 1: REQ expected next, 2: bubble expected
    logic        p_hold;
    logic [31:0] p_addr, p_pa;
    logic        p_pb;
    logic [31:0] acc_log[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stb"}, oPRED_SEARCH_STB, 0);
        check({tag, "_saddr"}, oPRED_SEARCH_ADDR, 0);
        check({tag, "_lock"}, oPRED_SEARCH_LOCK, 0);
        check({tag, "_req"}, oFETCH_REQ, 0);
        check({tag, "_addr"}, oFETCH_ADDR, 0);
        check({tag, "_pb"}, oFETCH_PRED_BRANCH, 0);
        check({tag, "_pa"}, oFETCH_PRED_ADDR, 0);
    endtask

    task automatic model_clear();
        mstate = 1; exp_next = 32'h100; redir_age = 0; bubble = 0;
        p_hold = 0; prev_stb = 0; prev_lock = 0; prev_saddr = 0;
        pv = 0; pb = 0; pa = 0;
    endtask

    task automatic do_reset();
        @(negedge iCLOCK);
        inRESET = 1'b0;
        iREDIRECT_VALID = 1'b1;
        iREDIRECT_ADDR = 32'h0000_7777;
        iHALT_REQ = 1'b0; iFETCH_BUSY = 1'b0;
        iPRED_VALID = 1'b0; iPRED_BRANCH = 1'b0; iPRED_ADDR = 32'h0;
        #1;
        check_zero("rst");
        @(negedge iCLOCK);
        inRESET = 1'b1;
        iREDIRECT_VALID = 1'b0;
        #1;
        check("rel_stb", oPRED_SEARCH_STB, 0);
        check("rel_req", oFETCH_REQ, 0);
        model_clear();
    endtask

    task automatic step(input logic redir, input logic [31:0] raddr,
                        input logic halt, input logic busy);
        logic        tk;
        logic [31:0] tgt;
        @(negedge iCLOCK);
        if (!prev_lock) begin
            pv = prev_stb;
            pb = 1'b0;
            pa = $urandom;
            if (!prev_stb) pb = ($urandom_range(0, 1) != 0);
            else if (btb.exists(prev_saddr)) begin
                pb = 1'b1;
                pa = btb[prev_saddr];
            end
        end
        iPRED_VALID = pv; iPRED_BRANCH = pb; iPRED_ADDR = pa;
        iREDIRECT_VALID = redir; iREDIRECT_ADDR = raddr;
        iHALT_REQ = halt; iFETCH_BUSY = busy;
        #1;
        check("lock", oPRED_SEARCH_LOCK, oFETCH_REQ && busy && !redir);
        if (oPRED_SEARCH_LOCK) check("stall_stb", oPRED_SEARCH_STB, 0);
        if (p_hold) begin
            check("hold_req", oFETCH_REQ, 1);
            check("hold_addr", oFETCH_ADDR, p_addr);
            check("hold_pb", oFETCH_PRED_BRANCH, p_pb);
            check("hold_pa", oFETCH_PRED_ADDR, p_pa);
        end
        if (mstate == 2) begin
            check("halt_stb", oPRED_SEARCH_STB, 0);
            check("halt_req", oFETCH_REQ, 0);
        end
        if (redir_age == 1 && !redir && !halt) begin
            check("redir_stb", oPRED_SEARCH_STB, 1);
            check("redir_saddr", oPRED_SEARCH_ADDR, redir_tgt);
        end
        if (redir_age == 2) begin
            check("redir_req", oFETCH_REQ, 1);
            check("redir_addr", oFETCH_ADDR, redir_tgt);
        end
        if (bubble == 1) check("seq_req", oFETCH_REQ, 1);
        if (bubble == 2) check("bubble_req", oFETCH_REQ, 0);
        bubble = 0;
        if (oFETCH_REQ && !busy && !redir) begin
            tk  = btb.exists(exp_next);
            tgt = tk ? (btb[exp_next] & MASK) : 32'h0;
            check("slot_addr", oFETCH_ADDR, exp_next);
            check("slot_pb", oFETCH_PRED_BRANCH, tk);
            check("slot_pa", oFETCH_PRED_ADDR, tgt);
            acc_log.push_back(oFETCH_ADDR);
            exp_next = tk ? tgt : exp_next + 32'd4;
            bubble = tk ? 2 : (halt ? 0 : 1);
        end
        if (redir_age == 1) redir_age = halt ? 0 : 2;
        else redir_age = 0;
        if (redir) begin
            mstate = 1;
            exp_next = raddr & MASK;
            redir_tgt = raddr & MASK;
            redir_age = 1;
            bubble = 2;
        end else if (mstate == 1 && halt && !(oFETCH_REQ && busy)) begin
            mstate = 2;
        end
        prev_stb = oPRED_SEARCH_STB;
        prev_saddr = oPRED_SEARCH_ADDR;
        prev_lock = oPRED_SEARCH_LOCK;
        p_hold = oFETCH_REQ && busy && !redir;
        p_addr = oFETCH_ADDR;
        p_pb = oFETCH_PRED_BRANCH;
        p_pa = oFETCH_PRED_ADDR;
    endtask

    initial begin
        btb[32'h0000_0108] = 32'h0000_2000;
        btb[32'h0000_3004] = 32'h0000_5000;
        model_clear();

        // reset release, sequential start, stall, taken prediction
        do_reset();
        step(0, 0, 0, 0);
        check("first_stb", oPRED_SEARCH_STB, 1);
        check("first_saddr", oPRED_SEARCH_ADDR, 32'h100);
        check("first_req", oFETCH_REQ, 0);
        step(0, 0, 0, 0);
        check("first_slot", oFETCH_ADDR, 32'h100);
        step(0, 0, 0, 1);
        check("stall_addr", oFETCH_ADDR, 32'h104);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("taken_pb", oFETCH_PRED_BRANCH, 1);
        check("taken_pa", oFETCH_PRED_ADDR, 32'h2000);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("after_bubble", oFETCH_ADDR, 32'h2000);

        // redirect during stall, then redirect against taken prediction
        step(0, 0, 0, 1);
        step(1, 32'h0000_3003, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 32'h0000_6000, 0, 0);
        check("redir_vs_taken_pb", oFETCH_PRED_BRANCH, 1);
        step(0, 0, 0, 0);
        check("redir_wins", oPRED_SEARCH_ADDR, 32'h6000);
        step(0, 0, 0, 0);

        // address wrap
        step(1, 32'hFFFF_FFF8, 0, 0);
        acc_log.delete();
        repeat (4) step(0, 0, 0, 0);
        check("wrap_n", acc_log.size() >= 3, 1);
        if (acc_log.size() >= 3) begin
            check("wrap0", acc_log[0], 32'hFFFF_FFF8);
            check("wrap1", acc_log[1], 32'hFFFF_FFFC);
            check("wrap2", acc_log[2], 32'h0000_0000);
        end

        // halt, then resume by redirect
        step(0, 0, 1, 0);
        check("halt_now_stb", oPRED_SEARCH_STB, 0);
        repeat (3) step(0, 0, 0, 0);
        step(1, 32'h0000_0040, 0, 0);
        acc_log.delete();
        repeat (3) step(0, 0, 0, 0);
        check("resume_n", acc_log.size() >= 1, 1);
        if (acc_log.size() >= 1) check("resume", acc_log[0], 32'h40);

        // asynchronous reset in the middle of a stall
        step(0, 0, 0, 1);
        #2;
        inRESET = 1'b0;
        #1;
        check_zero("async");
        do_reset();

        // random traffic
        for (int i = 0; i < 12; i++) begin
            btb[32'h8000 + 32'($urandom_range(0, 63)) * 4] =
                32'h8000 + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
        end
        step(1, 32'h8000, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            int          r;
            logic        rd, hl, bz;
            logic [31:0] ra;
            r  = $urandom_range(0, 99);
            rd = (mstate == 2) ? (r < 30) : (r < 4);
            ra = 32'h8000 + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
            hl = $urandom_range(0, 99) < 4;
            bz = $urandom_range(0, 99) < 30;
            step(rd, ra, hl, bz);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
